mux_scan_n: RTL and testbench
=============================

# mux_scan_n

Parametrised, registered N-channel, W-bit multiplexer with two modes. Manual mode selects a channel from an external select. Scan mode steps through all channels automatically, dwelling a fixed number of cycles on each. Out-of-range selects are handled explicitly: the output holds and an error flag is raised, so no latch is ever inferred. The block sits between grouped input sources (switch banks, sensor channels) and a single downstream consumer such as a display driver or serial sender.

## Interface
Parameters:
- N, 4: number of input channels; 2 ≤ N ≤ 2^SW.
- W, 1: bits per channel.
- SW, 2: select/channel-index width.
- DWELL, 8: cycles spent on each channel in scan mode; ≥ 1.

Ports:
- clk  in  1  rising-edge clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- en  in  1  advance enable; when low, all state holds.
- mode  in  1  0 = manual, 1 = scan.
- S  in  SW  manual channel select.
- D  in  N*W  packed channel data; channel k is D[k*W +: W].
- Q  out  W  registered selected data.
- ch  out  SW  index of the channel currently driving Q.
- sel_err  out  1  registered flag: the last manual select was ≥ N.
- ch_valid  out  1  one-cycle pulse: ch changed on the last edge.

## Operation
- Reset (rst=1 at an edge): Q=0, ch=0, sel_err=0, ch_valid=0, dwell counter=0. Reset overrides en and mode.
- en=0: Q, ch, sel_err and the counter hold; ch_valid=0.
- Manual mode (mode=0, en=1):
  - S < N: Q←D[S], ch←S, sel_err←0, ch_valid←(S≠ch). The dwell counter is cleared.
  - S ≥ N: Q and ch hold, sel_err←1, ch_valid←0. Q is never X or undefined.
- Scan mode (mode=1, en=1):
  - Q←D[ch] every cycle, so Q tracks live data on the current channel. sel_err←0.
  - The dwell counter counts 0..DWELL-1.
  - When the counter is at DWELL-1: counter←0, ch←(ch==N-1 ? 0 : ch+1), Q←D[next ch] on the same edge, ch_valid←1.
  - Otherwise: counter+1, ch_valid←0.
  - Wrap occurs at N-1, not at 2^SW-1, so out-of-range indices are never visited.
- Mode switches:
  - Manual→scan: scanning starts from the current ch with the counter at 0.
  - Scan→manual: S takes effect at the next edge and the counter is cleared.
- Invariant: after every edge, Q equals D[ch] as sampled at that edge, except in a hold (en=0 or bad S).
- DWELL=1: ch advances on every enabled edge and ch_valid stays high continuously.
- Counter width: ceil(log2(DWELL)), minimum 1 bit. The counter never exceeds DWELL-1.

## Timing
- Latency: one cycle from D/S to Q, ch and sel_err.
- ch_valid is aligned with the first cycle in which the new ch and Q are visible.
- Scan period: ch changes every DWELL enabled cycles. A full cycle through all channels takes N*DWELL enabled cycles.
- rst asserted mid-dwell or mid-error: the outputs take their reset values at that edge. After rst deasserts, a scan starts at ch=0 with a full DWELL.
- Simultaneous rst and en: rst wins. Simultaneous mode change and dwell expiry: the new mode's rule applies.

## Test plan
- Reset: assert rst for 2 cycles with D=4'b1010, mode=0, S=3 -> Q=0, ch=0, sel_err=0, ch_valid=0. On the first edge after release -> Q=1, ch=3, ch_valid=1.
- Manual sweep (N=4, W=1): D=4'b0110, S=0,1,2,3 on successive cycles -> Q=0,1,1,0 one cycle later each; ch_valid=1 on each change. Repeating S=2 -> ch_valid=0.
- Out of range (N=3, SW=2): S=1 with D=3'b010 -> Q=1. Then S=3 -> Q stays 1, ch stays 1, sel_err=1. Then S=0 -> Q=0, sel_err=0.
- Scan wrap (N=3, DWELL=2, W=4): D={4'hC,4'hB,4'hA}, mode=1 from reset -> ch sequence 0,0,1,1,2,2,0; Q sequence A,A,B,B,C,C,A; ch_valid pulses at each change only.
- Enable freeze: in scan with DWELL=4, drop en for 5 cycles mid-dwell -> ch, Q and counter hold. On re-enable, the remaining dwell completes and there are no extra ch_valid pulses.
- Mode switch: scanning at ch=2 with the counter at 1, set mode=0 with S=0 -> next edge ch=0. Return to mode=1 -> ch stays 0 for exactly DWELL cycles, then advances to 1.

Source files
------------

// File: rtl/mux_scan_n.sv
// Registered N-channel, W-bit multiplexer. In manual mode an external select picks the channel;
// in scan mode the block steps through the channels itself, staying DWELL cycles on each.
module mux_scan_n #(
  parameter int N     = 4,
  parameter int W     = 1,
  parameter int SW    = 2,
  parameter int DWELL = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            mode,
  input  logic [SW-1:0]   S,
  input  logic [N*W-1:0]  D,
  output logic [W-1:0]    Q,
  output logic [SW-1:0]   ch,
  output logic            sel_err,
  output logic            ch_valid
);

  localparam int CW              = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam int NCH             = 1 << SW;
  localparam logic [SW-1:0] LAST_CH  = SW'(N - 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DWELL - 1);

  // The table covers every select code, so indexing by any SW-bit value stays in range;
  // codes at or above N read as zero but are never latched into Q.
  logic [W-1:0] chan [NCH];

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      if (gi < N) begin : g_live
        assign chan[gi] = D[gi*W +: W];
      end else begin : g_pad
        assign chan[gi] = '0;
      end
    end
  endgenerate

  logic [W-1:0]  q_reg;
  logic [SW-1:0] ch_reg;
  logic          err_reg;
  logic          chv_reg;
  logic [CW-1:0] cnt_reg;
  logic [SW-1:0] ch_next;
  logic          s_ok;

  assign s_ok    = (32'(S) < 32'(N));
  assign ch_next = (ch_reg == LAST_CH) ? '0 : ch_reg + SW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg   <= '0;
      ch_reg  <= '0;
      err_reg <= 1'b0;
      chv_reg <= 1'b0;
      cnt_reg <= '0;
    end else if (!en) begin
      chv_reg <= 1'b0;
    end else if (!mode) begin
      // Manual: the counter is kept at zero so a later switch to scan gets a full dwell.
      cnt_reg <= '0;
      if (s_ok) begin
        q_reg   <= chan[S];
        ch_reg  <= S;
        err_reg <= 1'b0;
        chv_reg <= (S != ch_reg);
      end else begin
        err_reg <= 1'b1;
        chv_reg <= 1'b0;
      end
    end else begin
      err_reg <= 1'b0;
      if (cnt_reg == LAST_CNT) begin
        cnt_reg <= '0;
        ch_reg  <= ch_next;
        q_reg   <= chan[ch_next];
        chv_reg <= 1'b1;
      end else begin
        cnt_reg <= cnt_reg + CW'(1);
        q_reg   <= chan[ch_reg];
        chv_reg <= 1'b0;
      end
    end
  end

  assign Q        = q_reg;
  assign ch       = ch_reg;
  assign sel_err  = err_reg;
  assign ch_valid = chv_reg;

endmodule

// File: tb/tb_mux_scan_n.sv
// Scoreboard bench for mux_scan_n: directed scenarios followed by random traffic, each cycle's
// expected outputs come from a behavioural model and are checked by an independent monitor.
module tb_mux_scan_n;

  localparam int N     = 3;
  localparam int W     = 4;
  localparam int SW    = 2;
  localparam int DWELL = 3;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            en = 1'b0;
  logic            mode = 1'b0;
  logic [SW-1:0]   S = '0;
  logic [N*W-1:0]  D = '0;
  logic [W-1:0]    Q;
  logic [SW-1:0]   ch;
  logic            sel_err;
  logic            ch_valid;

  mux_scan_n #(.N(N), .W(W), .SW(SW), .DWELL(DWELL)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .S(S), .D(D),
    .Q(Q), .ch(ch), .sel_err(sel_err), .ch_valid(ch_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int q;
    int ch;
    int err;
    int v;
  } exp_t;

  exp_t expq[$];
  int   tests = 0;
  int   fails = 0;
  int   txn   = 0;

  // Reference model state: current channel, cycles already spent on it while scanning.
  int m_q = 0, m_ch = 0, m_err = 0, m_v = 0, m_spent = 0;

  function automatic int chan_of(logic [N*W-1:0] d, int k);
    logic [W-1:0] v;
    v = d[k*W +: W];
    return int'(v);
  endfunction

  task automatic model_step(input logic r, input logic e, input logic m,
                            input int s, input logic [N*W-1:0] d);
    if (r) begin
      m_q = 0; m_ch = 0; m_err = 0; m_v = 0; m_spent = 0;
    end else if (!e) begin
      m_v = 0;
    end else if (!m) begin
      m_spent = 0;
      if (s < N) begin
        m_v   = (s != m_ch) ? 1 : 0;
        m_ch  = s;
        m_q   = chan_of(d, s);
        m_err = 0;
      end else begin
        m_err = 1;
        m_v   = 0;
      end
    end else begin
      m_err   = 0;
      m_spent = m_spent + 1;
      if (m_spent == DWELL) begin
        m_spent = 0;
        m_ch    = (m_ch + 1) % N;
        m_v     = 1;
      end else begin
        m_v = 0;
      end
      m_q = chan_of(d, m_ch);
    end
  endtask

  task automatic cyc(input logic r, input logic e, input logic m,
                     input int s, input logic [N*W-1:0] d);
    exp_t x;
    @(negedge clk);
    rst = r; en = e; mode = m; S = SW'(s); D = d;
    model_step(r, e, m, s, d);
    x.q = m_q; x.ch = m_ch; x.err = m_err; x.v = m_v;
    expq.push_back(x);
  endtask

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("[TB] FAIL txn %0d %s: got %0d, expected %0d", txn, name, got, want);
    end
  endtask

  // Monitor: every edge produces one output set; compare it with the oldest expectation.
  initial begin
    exp_t x;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() != 0) begin
        x = expq.pop_front();
        txn++;
        check("Q", int'(Q), x.q);
        check("ch", int'(ch), x.ch);
        check("sel_err", int'(sel_err), x.err);
        check("ch_valid", int'(ch_valid), x.v);
        $display("[TB] txn %0d: rst=%0b en=%0b mode=%0b S=%0d D=%h -> Q=%h ch=%0d err=%0b v=%0b",
                 txn, rst, en, mode, S, D, Q, ch, sel_err, ch_valid);
      end
    end
  end

  initial begin
    logic [N*W-1:0] dd;
    int             budget;

    // Reset held two cycles with a bad select, then release into an error hold.
    cyc(1, 1, 0, 3, 12'h5A3);
    cyc(1, 1, 0, 3, 12'h5A3);
    cyc(0, 1, 0, 3, 12'h5A3);
    // Manual sweep including a repeated select.
    cyc(0, 1, 0, 0, 12'h6C1);
    cyc(0, 1, 0, 1, 12'h6C1);
    cyc(0, 1, 0, 2, 12'h6C1);
    cyc(0, 1, 0, 2, 12'h6C1);
    // Out of range: hold Q/ch and flag, then recover.
    cyc(0, 1, 0, 1, 12'h0F0);
    cyc(0, 1, 0, 3, 12'h000);
    cyc(0, 1, 0, 0, 12'h00E);
    // Scan wrap from reset.
    cyc(1, 0, 0, 0, 12'hCBA);
    for (int i = 0; i < N*DWELL + 2; i++) cyc(0, 1, 1, 0, 12'hCBA);
    // Enable freeze mid-dwell.
    cyc(1, 0, 0, 0, 12'h321);
    cyc(0, 1, 1, 0, 12'h321);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, 0, 12'h987);
    for (int i = 0; i < 4; i++) cyc(0, 1, 1, 0, 12'h654);
    // Mode switch: to manual at S=0, back to scan for more than one dwell.
    cyc(0, 1, 0, 0, 12'h654);
    for (int i = 0; i < DWELL + 2; i++) cyc(0, 1, 1, 2, 12'h654);
    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      dd = (N*W)'($urandom);
      cyc(($urandom_range(0, 49) == 0), ($urandom_range(0, 5) != 0),
          ($urandom_range(0, 3) != 0), int'($urandom_range(0, (1 << SW) - 1)), dd);
    end

    budget = 20;
    while (expq.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    if (expq.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain: %0d expectations left, expected 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
